// File: rtl/column_evaluator_pkg.sv
// Shared types for the day-6 worksheet column sweep: widths, operator encoding, FSM states.
package column_evaluator_pkg;
    localparam int ARG_ROW_WIDTH  = 3;
    localparam int ARG_COL_WIDTH  = 10;
    localparam int ARG_DATA_WIDTH = 16;
    localparam int RESULT_WIDTH   = 64;
    localparam int NUM_ROWS       = 2 ** ARG_ROW_WIDTH;

    typedef logic [ARG_ROW_WIDTH-1:0]  arg_row_t;
    typedef logic [ARG_ROW_WIDTH:0]    row_cnt_t;
    typedef logic [ARG_COL_WIDTH-1:0]  arg_col_t;
    typedef logic [ARG_DATA_WIDTH-1:0] arg_data_t;
    typedef logic [RESULT_WIDTH-1:0]   result_t;

    typedef enum logic {OP_ADD = 1'b0, OP_MUL = 1'b1} op_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_LATCH,
        ST_REDUCE,
        ST_ACCUM,
        ST_DONE
    } state_t;

    // A zero row count still reduces row 0; counts beyond the store depth saturate.
    function automatic row_cnt_t clamp_rows(input row_cnt_t n);
        if (n == '0) return row_cnt_t'(1);
        if (n > row_cnt_t'(NUM_ROWS)) return row_cnt_t'(NUM_ROWS);
        return n;
    endfunction
endpackage

// File: rtl/column_reducer.sv
// Column accumulator: loads the first row word, then folds further rows with add or multiply.
module column_reducer
    import column_evaluator_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      init,
    input  logic      step,
    input  op_t       op,
    input  arg_data_t init_val,
    input  arg_data_t operand,
    output result_t   acc
);
    result_t operand_ext;

    assign operand_ext = result_t'(operand);

    // Products and sums wrap modulo 2**RESULT_WIDTH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
        end else if (init) begin
            acc <= result_t'(init_val);
        end else if (step) begin
            acc <= (op == OP_MUL) ? acc * operand_ext : acc + operand_ext;
        end
    end
endmodule

// File: rtl/column_evaluator.sv
// Sweeps worksheet columns, reduces each with its operator and accumulates the grand total.
module column_evaluator
    import column_evaluator_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      start,
    input  arg_col_t  col_count,
    input  row_cnt_t  row_count,
    output arg_col_t  rd_arg_col,
    input  arg_data_t rd_arg_data_row0,
    input  arg_data_t rd_arg_data_row1,
    input  arg_data_t rd_arg_data_row2,
    input  arg_data_t rd_arg_data_row3,
    input  arg_data_t rd_arg_data_row4,
    input  arg_data_t rd_arg_data_row5,
    input  arg_data_t rd_arg_data_row6,
    input  arg_data_t rd_arg_data_row7,
    output arg_col_t  rd_op_col,
    input  logic      rd_op,
    output logic      busy,
    output logic      col_result_valid,
    output result_t   col_result,
    output result_t   total,
    output logic      done,
    output logic      total_valid
);
    state_t   state, state_nxt;
    arg_col_t col, cols_q;
    row_cnt_t rows_q;
    arg_row_t row;
    op_t      op_q;
    logic     red_init, red_step;
    result_t  acc;

    logic [NUM_ROWS-1:0][ARG_DATA_WIDTH-1:0] row_in, row_vec;

    assign row_in = {rd_arg_data_row7, rd_arg_data_row6, rd_arg_data_row5, rd_arg_data_row4,
                     rd_arg_data_row3, rd_arg_data_row2, rd_arg_data_row1, rd_arg_data_row0};

    assign rd_arg_col = col;
    assign rd_op_col  = col;
    assign busy       = (state != ST_IDLE) && (state != ST_DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        red_init  = 1'b0;
        red_step  = 1'b0;
        case (state)
            ST_IDLE, ST_DONE: if (start) state_nxt = (col_count == '0) ? ST_DONE : ST_FETCH;
            ST_FETCH:         state_nxt = ST_LATCH;
            ST_LATCH: begin
                red_init  = 1'b1;
                state_nxt = (rows_q == row_cnt_t'(1)) ? ST_ACCUM : ST_REDUCE;
            end
            ST_REDUCE: begin
                red_step = 1'b1;
                if ({1'b0, row} == rows_q - 1'b1) state_nxt = ST_ACCUM;
            end
            ST_ACCUM:         state_nxt = (col == cols_q - 1'b1) ? ST_DONE : ST_FETCH;
            default:          state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col              <= '0;
            cols_q           <= '0;
            rows_q           <= '0;
            row              <= '0;
            op_q             <= OP_ADD;
            row_vec          <= '0;
            col_result_valid <= 1'b0;
            col_result       <= '0;
            total            <= '0;
            done             <= 1'b0;
            total_valid      <= 1'b0;
        end else begin
            col_result_valid <= 1'b0;
            done             <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        cols_q <= col_count;
                        rows_q <= clamp_rows(row_count);
                        col    <= '0;
                        total  <= '0;
                        // An empty sheet completes immediately with a zero total.
                        done        <= (col_count == '0);
                        total_valid <= (col_count == '0);
                    end
                end
                ST_LATCH: begin
                    row_vec <= row_in;
                    op_q    <= op_t'(rd_op);
                    row     <= arg_row_t'(1);
                end
                ST_REDUCE: row <= row + 1'b1;
                ST_ACCUM: begin
                    col_result       <= acc;
                    col_result_valid <= 1'b1;
                    total            <= total + acc;
                    if (col == cols_q - 1'b1) begin
                        done        <= 1'b1;
                        total_valid <= 1'b1;
                    end else begin
                        col <= col + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Row 0 seeds the accumulator straight from the store read port during LATCH.
    column_reducer u_reducer (
        .clk     (clk),
        .rst     (rst),
        .init    (red_init),
        .step    (red_step),
        .op      (op_q),
        .init_val(row_in[0]),
        .operand (row_vec[row]),
        .acc     (acc)
    );
endmodule

// File: tb/tb_column_evaluator.sv
// Directed bench for column_evaluator: single-column vector table plus multi-column sequences.
module tb_column_evaluator;
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [9:0]  col_count;
    logic [3:0]  row_count;
    logic [9:0]  rd_arg_col, rd_op_col;
    logic [15:0] rd_row [8];
    logic        rd_op;
    logic        busy, col_result_valid, done, total_valid;
    logic [63:0] col_result, total;

    logic [15:0] mem [8][16];
    logic        opm [16];

    int n_vec = 0;
    int n_err = 0;

    logic [63:0] res_q [$];
    int          first_lat, done_lat, done_cnt;
    logic        tv0, busy0, tv_end, busy_end, seen_done;
    logic [63:0] tot0;

    localparam logic [63:0] P8 = 64'hFFC8_001B_FFF8_0001;  // 65535**8 mod 2**64

    typedef struct {
        logic [7:0][15:0] rows;
        logic             op;
        logic [3:0]       rc;
        logic [63:0]      exp_res;
        int               exp_lat;
    } vec_t;
    vec_t vt [11];

    column_evaluator dut (
        .clk(clk), .rst(rst), .start(start), .col_count(col_count), .row_count(row_count),
        .rd_arg_col(rd_arg_col),
        .rd_arg_data_row0(rd_row[0]), .rd_arg_data_row1(rd_row[1]),
        .rd_arg_data_row2(rd_row[2]), .rd_arg_data_row3(rd_row[3]),
        .rd_arg_data_row4(rd_row[4]), .rd_arg_data_row5(rd_row[5]),
        .rd_arg_data_row6(rd_row[6]), .rd_arg_data_row7(rd_row[7]),
        .rd_op_col(rd_op_col), .rd_op(rd_op), .busy(busy),
        .col_result_valid(col_result_valid), .col_result(col_result), .total(total),
        .done(done), .total_valid(total_valid)
    );

    always #5 clk = ~clk;

    // Argument and operator stores with one-cycle read latency.
    always @(posedge clk) begin
        for (int i = 0; i < 8; i++) rd_row[i] <= mem[i][rd_arg_col[3:0]];
        rd_op <= opm[rd_op_col[3:0]];
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%h) expected %0d (0x%h)", name, act, act, exp, exp);
        end
    endtask

    task automatic do_start(input int cc, input int rc);
        @(negedge clk);
        col_count = cc[9:0];
        row_count = rc[3:0];
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Samples once per cycle on the falling edge; k=0 is just after the edge that took start.
    task automatic collect(input int budget);
        res_q.delete();
        first_lat = -1; done_lat = -1; done_cnt = 0; seen_done = 1'b0;
        tv0 = total_valid; busy0 = busy; tot0 = total;
        for (int k = 0; k < budget; k++) begin
            if (col_result_valid) begin
                res_q.push_back(col_result);
                if (first_lat < 0) first_lat = k;
            end
            if (done) begin
                done_cnt++;
                if (done_lat < 0) done_lat = k;
            end
            if (seen_done) break;
            if (done) seen_done = 1'b1;
            @(negedge clk);
        end
        tv_end = total_valid; busy_end = busy;
        check("sweep_finished", seen_done, 1'b1);
    endtask

    function automatic logic [63:0] res_at(input int i);
        return (i < res_q.size()) ? res_q[i] : 64'hx;
    endfunction

    task automatic load_sheet();
        int a [3][4] = '{'{123, 328, 51, 64}, '{45, 64, 387, 23}, '{6, 98, 215, 314}};
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 3; r++) mem[r][c] = a[r][c][15:0];
            for (int r = 3; r < 8; r++) mem[r][c] = 16'd999;
        end
        opm[0] = 1'b1; opm[1] = 1'b0; opm[2] = 1'b1; opm[3] = 1'b0;
    endtask

    task automatic check_sheet(input string tag);
        check({tag, "_ncols"}, res_q.size(), 4);
        check({tag, "_c0"}, res_at(0), 64'd33210);
        check({tag, "_c1"}, res_at(1), 64'd490);
        check({tag, "_c2"}, res_at(2), 64'd4243455);
        check({tag, "_c3"}, res_at(3), 64'd401);
        check({tag, "_total"}, total, 64'd4277556);
        check({tag, "_done_cnt"}, done_cnt, 1);
        check({tag, "_total_valid"}, tv_end, 1'b1);
    endtask

    initial begin
        vt[0]  = '{{{7{16'd9}}, 16'd7}, 1'b1, 4'd1, 64'd7, 3};
        vt[1]  = '{{{7{16'd9}}, 16'd7}, 1'b1, 4'd0, 64'd7, 3};
        vt[2]  = '{{16'd8, 16'd7, 16'd6, 16'd5, 16'd4, 16'd3, 16'd2, 16'd1}, 1'b0, 4'd8, 64'd36, 10};
        vt[3]  = '{{16'd8, 16'd7, 16'd6, 16'd5, 16'd4, 16'd3, 16'd2, 16'd1}, 1'b1, 4'd8, 64'd40320, 10};
        vt[4]  = '{{16'd8, 16'd7, 16'd6, 16'd5, 16'd4, 16'd3, 16'd2, 16'd1}, 1'b1, 4'd15, 64'd40320, 10};
        vt[5]  = '{{16'd8, 16'd7, 16'd6, 16'd5, 16'd4, 16'd3, 16'd2, 16'd1}, 1'b1, 4'd9, 64'd40320, 10};
        vt[6]  = '{{16'd9, 16'd8, 16'd7, 16'd6, 16'd5, 16'd4, 16'd3, 16'd2}, 1'b0, 4'd2, 64'd5, 4};
        vt[7]  = '{{8{16'hFFFF}}, 1'b1, 4'd8, P8, 10};
        vt[8]  = '{{8{16'hFFFF}}, 1'b0, 4'd8, 64'd524280, 10};
        vt[9]  = '{{{6{16'd5}}, 16'd5, 16'd0}, 1'b1, 4'd2, 64'd0, 4};
        vt[10] = '{{{4{16'd9}}, 16'd5, 16'd4, 16'd3, 16'd2}, 1'b1, 4'd4, 64'd120, 6};

        for (int r = 0; r < 8; r++) for (int c = 0; c < 16; c++) mem[r][c] = '0;
        for (int c = 0; c < 16; c++) opm[c] = 1'b0;
        rst = 1'b1; start = 1'b0; col_count = '0; row_count = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_total_valid", total_valid, 1'b0);
        check("rst_total", total, 64'd0);
        check("rst_col_result", col_result, 64'd0);
        check("rst_col_result_valid", col_result_valid, 1'b0);
        check("rst_rd_arg_col", rd_arg_col, 64'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 11; i++) begin
            for (int r = 0; r < 8; r++) mem[r][0] = vt[i].rows[r];
            opm[0] = vt[i].op;
            do_start(1, int'(vt[i].rc));
            collect(40);
            check($sformatf("vec%0d_ncols", i), res_q.size(), 1);
            check($sformatf("vec%0d_result", i), res_at(0), vt[i].exp_res);
            check($sformatf("vec%0d_latency", i), first_lat, vt[i].exp_lat);
            check($sformatf("vec%0d_total", i), total, vt[i].exp_res);
            check($sformatf("vec%0d_done_cnt", i), done_cnt, 1);
            check($sformatf("vec%0d_total_valid", i), tv_end, 1'b1);
            check($sformatf("vec%0d_busy_end", i), busy_end, 1'b0);
        end

        // Worksheet example; the previous nonzero total must be cleared by start.
        load_sheet();
        do_start(4, 3);
        collect(100);
        check("sheet_busy_start", busy0, 1'b1);
        check("sheet_tv_start", tv0, 1'b0);
        check("sheet_total_start", tot0, 64'd0);
        check("sheet_latency", first_lat, 5);
        check_sheet("sheet");

        // Re-sweep from DONE.
        do_start(4, 3);
        collect(100);
        check("b2b_tv_start", tv0, 1'b0);
        check("b2b_total_start", tot0, 64'd0);
        check_sheet("b2b");

        // Empty sheet.
        do_start(0, 3);
        collect(10);
        check("empty_ncols", res_q.size(), 0);
        check("empty_done_lat", done_lat, 0);
        check("empty_done_cnt", done_cnt, 1);
        check("empty_total", total, 64'd0);
        check("empty_total_valid", tv_end, 1'b1);

        // Two saturated product columns wrap the grand total.
        for (int c = 0; c < 2; c++) begin
            for (int r = 0; r < 8; r++) mem[r][c] = 16'hFFFF;
            opm[c] = 1'b1;
        end
        do_start(2, 8);
        collect(60);
        check("wrap_c0", res_at(0), P8);
        check("wrap_c1", res_at(1), P8);
        check("wrap_total", total, 64'hFF90_0037_FFF0_0002);

        // A start arriving while in REDUCE must not disturb the sweep.
        load_sheet();
        do_start(4, 3);
        repeat (2) @(negedge clk);
        do_start(1, 1);
        collect(100);
        check_sheet("midstart");

        // Async reset while reducing column 1.
        do_start(4, 3);
        for (int k = 0; k < 20 && !col_result_valid; k++) @(negedge clk);
        check("rstmid_first_valid", col_result_valid, 1'b1);
        repeat (2) @(negedge clk);
        check("rstmid_col_before", rd_arg_col, 64'd1);
        check("rstmid_busy_before", busy, 1'b1);
        #2 rst = 1'b1;
        #1;
        check("rstmid_busy", busy, 1'b0);
        check("rstmid_col_result", col_result, 64'd0);
        check("rstmid_total", total, 64'd0);
        check("rstmid_rd_arg_col", rd_arg_col, 64'd0);
        check("rstmid_total_valid", total_valid, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check("rstmid_idle_busy", busy, 1'b0);
        check("rstmid_idle_valid", col_result_valid, 1'b0);
        check("rstmid_idle_done", done, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
